// File: rtl/beep_pattern_timer.sv
// Step/tick sequencer for the end-of-game beeper: walks an 8-step pattern at TICK_HZ.
// Define BEEP_REPEAT_EN to stop in HOLD after REPEATS passes; otherwise the pattern loops forever.
module beep_pattern_timer #(
  parameter int unsigned CLK_FREQ = 50000000,
  parameter int unsigned TICK_HZ  = 4,
  parameter int unsigned REPEATS  = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw6,
  input  logic [1:0] gameState,
  output logic [2:0] count_8_4Hz,
  output logic       tick_4Hz,
  output logic       busy
);

  localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
  localparam int unsigned DivW  = $clog2(DIV);
  localparam int unsigned PassW = $clog2(REPEATS + 1);
  localparam logic [DivW-1:0] DivLast = DivW'(DIV - 1);

  typedef enum logic [1:0] {StIdle, StRun, StHold} state_e;

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [PassW-1:0] pass_q, pass_d;
  logic [1:0]       gs_prev_q;
  logic [2:0]       count_d;
  logic             tick_d, busy_d;

  logic start, abort, step_end, pass_end, limit, cont;

  assign start    = sw6 && (gameState <= 2'd1) && (gameState != gs_prev_q);
  assign abort    = !sw6 || (gameState >= 2'd2);
  assign step_end = (state_q == StRun) && (div_q == DivLast);
  assign pass_end = step_end && (count_8_4Hz == 3'd7);
  // Continue the current run: no abort and no restart this cycle.
  assign cont     = (state_q == StRun) && !start && !abort;

`ifdef BEEP_REPEAT_EN
  localparam logic [PassW-1:0] PassLast = PassW'(REPEATS - 1);
  assign limit = pass_end && (pass_q == PassLast);
`else
  assign limit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      div_q       <= '0;
      pass_q      <= '0;
      gs_prev_q   <= 2'd2;
      count_8_4Hz <= 3'd0;
      tick_4Hz    <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      pass_q      <= pass_d;
      gs_prev_q   <= gameState;
      count_8_4Hz <= count_d;
      tick_4Hz    <= tick_d;
      busy        <= busy_d;
    end
  end

  // Abort beats restart, restart beats the pass limit.
  always_comb begin
    state_d = state_q;
    div_d   = '0;
    pass_d  = '0;
    if (abort) begin
      state_d = StIdle;
    end else if (start) begin
      state_d = StRun;
    end else if (limit) begin
      state_d = StHold;
    end
    if (cont) begin
      div_d  = step_end ? '0 : div_q + 1'b1;
      pass_d = pass_end ? pass_q + 1'b1 : pass_q;
    end
  end

  always_comb begin
    count_d = 3'd0;
    tick_d  = 1'b0;
    busy_d  = 1'b0;
    unique case (state_d)
      StRun: begin
        busy_d = 1'b1;
        if (cont) begin
          count_d = step_end ? count_8_4Hz + 3'd1 : count_8_4Hz;
          tick_d  = step_end;
        end
      end
      // Step 1 is silent in both beep patterns.
      StHold:  count_d = 3'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_beep_pattern_timer.sv
// Bench for beep_pattern_timer: vector table, directed corner sequences, then random
// stimulus against a time-since-entry arithmetic model. Honours BEEP_REPEAT_EN.
module tb_beep_pattern_timer;

  localparam int unsigned CLK_FREQ = 40;
  localparam int unsigned TICK_HZ  = 4;
  localparam int unsigned REPEATS  = 2;
  localparam int DIV      = 10;
  localparam int PASS_LEN = 8 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sw6 = 1'b0;
  logic [1:0] gameState = 2'd2;
  logic [2:0] count_8_4Hz;
  logic       tick_4Hz;
  logic       busy;

  always #5 clk = ~clk;

  beep_pattern_timer #(
    .CLK_FREQ(CLK_FREQ),
    .TICK_HZ (TICK_HZ),
    .REPEATS (REPEATS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw6        (sw6),
    .gameState  (gameState),
    .count_8_4Hz(count_8_4Hz),
    .tick_4Hz   (tick_4Hz),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 run, 2 hold; t = cycles elapsed since entering run.
  int         m_mode = 0;
  int         m_t = 0;
  logic [1:0] m_gs_prev = 2'd2;
  int         e_count, e_tick, e_busy;

  typedef struct {
    logic       r;
    logic       s;
    logic [1:0] g;
    logic [2:0] count;
    logic       tick;
    logic       busy;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [1:0] g);
    logic st, ab;
    if (r) begin
      m_mode    = 0;
      m_t       = 0;
      m_gs_prev = 2'd2;
    end else begin
      ab = !s || (g >= 2'd2);
      st = s && (g <= 2'd1) && (g != m_gs_prev);
      if (ab) begin
        m_mode = 0;
        m_t    = 0;
      end else if (st) begin
        m_mode = 1;
        m_t    = 0;
      end else if (m_mode == 1) begin
        m_t++;
`ifdef BEEP_REPEAT_EN
        if (m_t >= int'(REPEATS) * PASS_LEN) m_mode = 2;
`endif
      end
      m_gs_prev = g;
    end
    case (m_mode)
      1: begin
        e_count = (m_t / DIV) % 8;
        e_tick  = (m_t != 0 && m_t % DIV == 0) ? 1 : 0;
        e_busy  = 1;
      end
      2: begin
        e_count = 1;
        e_tick  = 0;
        e_busy  = 0;
      end
      default: begin
        e_count = 0;
        e_tick  = 0;
        e_busy  = 0;
      end
    endcase
  endtask

  task automatic step(input logic r, input logic s, input logic [1:0] g, input string tag);
    rst       = r;
    sw6       = s;
    gameState = g;
    @(posedge clk);
    model_edge(r, s, g);
    #1;
    check({tag, " count"}, int'(count_8_4Hz), e_count);
    check({tag, " tick"}, int'(tick_4Hz), e_tick);
    check({tag, " busy"}, int'(busy), e_busy);
  endtask

  task automatic steps(input int n, input logic s, input logic [1:0] g, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, s, g, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic       r, s;
    logic [1:0] g;

    // Reset, then win entry through the first two step boundaries.
    for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b0, 2'd2, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 3'd0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b1});
    for (int i = 0; i < 9; i++) tbl.push_back('{1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 3'd1, 1'b1, 1'b1});
    for (int i = 0; i < 9; i++) tbl.push_back('{1'b0, 1'b1, 2'd1, 3'd1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 1'b1, 2'd1, 3'd2, 1'b1, 1'b1});

    foreach (tbl[i]) begin
      step(tbl[i].r, tbl[i].s, tbl[i].g, "vec");
      check($sformatf("tbl[%0d] count", i), int'(count_8_4Hz), int'(tbl[i].count));
      check($sformatf("tbl[%0d] tick", i), int'(tick_4Hz), int'(tbl[i].tick));
      check($sformatf("tbl[%0d] busy", i), int'(busy), int'(tbl[i].busy));
    end

    // Continue to t=80: count wraps 7 -> 0 with a tick.
    steps(60, 1'b1, 2'd1, "win");
    check("win wrap count", int'(count_8_4Hz), 0);
    check("win wrap tick", int'(tick_4Hz), 1);

    // Lose entry, run two full passes.
    step(1'b0, 1'b1, 2'd2, "lose idle");
    step(1'b0, 1'b1, 2'd0, "lose entry");
    steps(160, 1'b1, 2'd0, "lose");
`ifdef BEEP_REPEAT_EN
    check("hold count", int'(count_8_4Hz), 1);
    check("hold busy", int'(busy), 0);
    check("hold tick", int'(tick_4Hz), 0);
    steps(30, 1'b1, 2'd0, "hold");
    check("hold stays tick", int'(tick_4Hz), 0);
    check("hold stays count", int'(count_8_4Hz), 1);
`else
    check("norepeat t160 count", int'(count_8_4Hz), 0);
    steps(250, 1'b1, 2'd0, "norepeat");
    check("norepeat t410 count", int'(count_8_4Hz), 1);
    check("norepeat t410 tick", int'(tick_4Hz), 1);
    check("norepeat busy", int'(busy), 1);
`endif

    // Start coinciding with the final-pass tick: start wins.
    step(1'b0, 1'b1, 2'd2, "coinc idle");
    step(1'b0, 1'b1, 2'd1, "coinc entry");
    steps(159, 1'b1, 2'd1, "coinc run");
    step(1'b0, 1'b1, 2'd0, "coinc restart");
    check("coinc count", int'(count_8_4Hz), 0);
    check("coinc tick", int'(tick_4Hz), 0);
    check("coinc busy", int'(busy), 1);

    // Restart at count 5, then abort via sw6.
    step(1'b0, 1'b1, 2'd2, "rs idle");
    step(1'b0, 1'b1, 2'd1, "rs entry");
    steps(50, 1'b1, 2'd1, "rs run");
    check("rs at five", int'(count_8_4Hz), 5);
    step(1'b0, 1'b1, 2'd0, "rs restart");
    check("rs restart count", int'(count_8_4Hz), 0);
    check("rs restart busy", int'(busy), 1);
    steps(23, 1'b1, 2'd0, "rs run2");
    step(1'b0, 1'b0, 2'd0, "abort");
    check("abort count", int'(count_8_4Hz), 0);
    check("abort busy", int'(busy), 0);

    // Mid-run reset with gameState held at 0.
    step(1'b0, 1'b1, 2'd2, "mr idle");
    step(1'b0, 1'b1, 2'd0, "mr entry");
    steps(25, 1'b1, 2'd0, "mr run");
    step(1'b1, 1'b1, 2'd0, "mr reset");
    check("mr reset busy", int'(busy), 0);
    check("mr reset count", int'(count_8_4Hz), 0);
    step(1'b0, 1'b1, 2'd0, "mr release");
    check("mr release busy", int'(busy), 1);
    check("mr release count", int'(count_8_4Hz), 0);
    steps(10, 1'b1, 2'd0, "mr run2");
    check("mr first tick", int'(tick_4Hz), 1);

    // Random stimulus against the model.
    g = 2'd2;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 199) == 0);
      s = ($urandom_range(0, 29) != 0);
      if ($urandom_range(0, 59) == 0) g = 2'($urandom_range(0, 3));
      step(r, s, g, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
